// File: rtl/cacheline_burst_adapter.sv
// Cacheline <-> burst-memory adapter: splits a LINE_BITS write into BEAT_BITS beats and
// assembles read beats into a line. Define BURST_ADAPTER_PERF_EN to enable perf counters.
module cacheline_burst_adapter #(
   parameter int unsigned LINE_BITS = 256,
   parameter int unsigned BEAT_BITS = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          dfp_addr,
   input  logic                 dfp_read,
   input  logic                 dfp_write,
   input  logic [LINE_BITS-1:0] dfp_wdata,
   output logic [LINE_BITS-1:0] dfp_rdata,
   output logic                 dfp_resp,
   output logic [31:0]          bmem_addr,
   output logic                 bmem_read,
   output logic                 bmem_write,
   output logic [BEAT_BITS-1:0] bmem_wdata,
   input  logic                 bmem_ready,
   input  logic [BEAT_BITS-1:0] bmem_rdata,
   input  logic                 bmem_rvalid,
   output logic                 protocol_err,
   output logic [31:0]          perf_rd_cnt,
   output logic [31:0]          perf_wr_cnt
);

   localparam int unsigned BEATS = LINE_BITS / BEAT_BITS;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned IDX_W = $clog2(LINE_BITS);

   typedef enum logic [2:0] {
      IDLE,
      WR_BURST,
      RD_REQ,
      RD_COLLECT,
      RESP
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [31:0]            r_addr;
   logic [LINE_BITS-1:0]   r_line;
   logic [LINE_BITS-1:0]   r_rdata;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_err;
   logic                   w_last;
   logic                   w_accept;
   logic [IDX_W-1:0]       w_base;
   logic                   w_unused_addr;

   // low address bits select a byte within the line and are intentionally dropped
   assign w_unused_addr = ^dfp_addr[4:0];

   assign w_last   = (r_cnt == CNT_W'(BEATS - 1));
   assign w_accept = dfp_write | dfp_read;
   assign w_base   = IDX_W'(r_cnt) * IDX_W'(BEAT_BITS);

   assign dfp_rdata    = r_rdata;
   assign protocol_err = r_err;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // next-state and bus-side decode
   always_comb begin
      w_next     = r_state;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;
      bmem_addr  = '0;
      dfp_resp   = 1'b0;
      case (r_state)
         IDLE: begin
            if (dfp_write)     w_next = WR_BURST;
            else if (dfp_read) w_next = RD_REQ;
         end
         WR_BURST: begin
            bmem_addr  = r_addr;
            bmem_write = 1'b1;
            bmem_wdata = r_line[w_base +: BEAT_BITS];
            if (bmem_ready && w_last) w_next = RESP;
         end
         RD_REQ: begin
            bmem_addr = r_addr;
            bmem_read = 1'b1;
            if (bmem_ready) w_next = RD_COLLECT;
         end
         RD_COLLECT: begin
            bmem_addr = r_addr;
            if (bmem_rvalid && w_last) w_next = RESP;
         end
         RESP: begin
            bmem_addr = r_addr;
            dfp_resp  = 1'b1;
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // request latch, beat counter, read-line assembly and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_line  <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (bmem_rvalid && (r_state != RD_COLLECT)) r_err <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr <= {dfp_addr[31:5], 5'b0};
                  r_line <= dfp_wdata;
                  r_cnt  <= '0;
               end
            end
            WR_BURST: begin
               if (bmem_ready) r_cnt <= r_cnt + CNT_W'(1);
            end
            RD_COLLECT: begin
               if (bmem_rvalid) begin
                  r_rdata[w_base +: BEAT_BITS] <= bmem_rdata;
                  r_cnt                        <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BURST_ADAPTER_PERF_EN
   logic        r_is_wr;
   logic [31:0] r_rd_cnt;
   logic [31:0] r_wr_cnt;

   // completed-line counters, bumped as the response is issued
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_wr  <= 1'b0;
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if ((r_state == IDLE) && w_accept) r_is_wr <= dfp_write;
         if (r_state == RESP) begin
            if (r_is_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
            else         r_rd_cnt <= r_rd_cnt + 32'd1;
         end
      end
   end

   assign perf_rd_cnt = r_rd_cnt;
   assign perf_wr_cnt = r_wr_cnt;
`else
   assign perf_rd_cnt = '0;
   assign perf_wr_cnt = '0;
`endif

endmodule
